// File: rtl/pipe_pkg.sv
// elastic_pipe shared package
// count-width helper and default reset payload
package pipe_pkg;

  localparam int unsigned RST_VAL_DEF = 0;

  function automatic int cw_of(input int depth);
    return (depth < 1) ? 1 : $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// elastic_pipe handshake bundle
// master drives upstream side and downstream ready
interface elastic_pipe_if
  import pipe_pkg::*;
#(
  parameter int DW    = 5,
  parameter int DEPTH = 2,
  parameter int CW    = cw_of(DEPTH)
);

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  modport master (
    output flush,
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  flush,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface

// File: rtl/pipe_slice.sv
// one 2-entry skid register slice
// in_ready comes straight from the skid flag
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int            DW      = 5,
  parameter logic [DW-1:0] RST_VAL = DW'(RST_VAL_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          m_v;
  logic          s_v;
  logic [DW-1:0] m_d;
  logic [DW-1:0] s_d;
  logic          acc;
  logic          take;

  assign in_ready  = !s_v;
  assign out_valid = m_v;
  assign out_data  = m_d;
  assign acc       = in_valid & !s_v;
  assign take      = !m_v | out_ready;

  // main refills from skid first so order is kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
      m_d <= RST_VAL;
      s_d <= RST_VAL;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (take) begin
      if (s_v) begin
        m_v <= 1'b1;
        m_d <= s_d;
        s_v <= 1'b0;
      end else begin
        m_v <= acc;
        if (acc) m_d <= in_data;
      end
    end else if (acc) begin
      s_v <= 1'b1;
      s_d <= in_data;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// elastic_pipe: DEPTH skid slices with occupancy count
// DEPTH = 0 collapses to wires
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int            DW      = 5,
  parameter int            DEPTH   = 2,
  parameter logic [DW-1:0] RST_VAL = DW'(RST_VAL_DEF),
  parameter int            CW      = cw_of(DEPTH)
) (
  input logic           clk,
  input logic           rst,
  elastic_pipe_if.slave p
);

  if (DEPTH == 0) begin : g_wire

    assign p.out_valid = p.in_valid;
    assign p.in_ready  = p.out_ready;
    assign p.out_data  = p.in_data;
    assign p.count     = '0;

  end else begin : g_pipe

    logic [DEPTH:0] v;
    logic [DEPTH:0] r;
    logic [DW-1:0]  d [0:DEPTH];
    logic [CW-1:0]  cnt_q;
    logic           acc;
    logic           cons;

    assign v[0]        = p.in_valid;
    assign d[0]        = p.in_data;
    assign p.in_ready  = r[0];
    assign r[DEPTH]    = p.out_ready;
    assign p.out_valid = v[DEPTH];
    assign p.out_data  = d[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slice
      pipe_slice #(
        .DW      (DW),
        .RST_VAL (RST_VAL)
      ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .flush     (p.flush),
        .in_valid  (v[i]),
        .in_ready  (r[i]),
        .in_data   (d[i]),
        .out_valid (v[i+1]),
        .out_ready (r[i+1]),
        .out_data  (d[i+1])
      );
    end

    assign acc  = p.in_valid & r[0];
    assign cons = v[DEPTH] & p.out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (p.flush) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(acc) - CW'(cons);
      end
    end

    assign p.count = cnt_q;

  end

endmodule

// File: tb/tb_elastic_pipe.sv
// elastic_pipe bench: directed table on DEPTH=2,
// scoreboard stress on DEPTH 0/1/3
module tb_elastic_pipe;
  import pipe_pkg::*;

  logic clk;
  logic rst;
  logic rst_r;
  logic go;
  int   n_chk;
  int   n_fail;
  int   done_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  elastic_pipe_if #(.DW(5), .DEPTH(2)) di ();

  elastic_pipe #(
    .DW      (5),
    .DEPTH   (2),
    .RST_VAL (5'h15)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .p   (di.slave)
  );

  typedef struct {
    logic       iv;
    logic [4:0] id;
    logic       ordy;
    logic       fl;
    logic       eir;
    logic       eov;
    logic [4:0] eod;
    logic [2:0] ecnt;
  } vec_t;

  vec_t tbl [17];

  task automatic obs(input string nm, input logic eir,
                     input logic eov, input logic [4:0] eod,
                     input logic [2:0] ecnt);
    check({nm, "_in_ready"}, 32'(di.in_ready), 32'(eir));
    check({nm, "_out_valid"}, 32'(di.out_valid), 32'(eov));
    check({nm, "_out_data"}, 32'(di.out_data), 32'(eod));
    check({nm, "_count"}, 32'(di.count), 32'(ecnt));
  endtask

  // randomized stress instances, one per depth
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int D = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    elastic_pipe_if #(.DW(8), .DEPTH(D)) ifr ();

    elastic_pipe #(
      .DW      (8),
      .DEPTH   (D),
      .RST_VAL (8'h00)
    ) u_r (
      .clk (clk),
      .rst (rst_r),
      .p   (ifr.slave)
    );

    initial begin : stress
      logic [7:0] q [$];
      logic [7:0] wd;
      logic       iv;
      logic       ordy;
      logic       fl;
      logic       acc;
      logic       cons;
      int         thr;
      string      tag;
      tag = $sformatf("d%0d", D);
      ifr.in_valid  = 1'b0;
      ifr.in_data   = '0;
      ifr.out_ready = 1'b0;
      ifr.flush     = 1'b0;
      wait (go);
      for (int c = 0; c < 10040; c++) begin
        @(negedge clk);
        thr = ((c / 1000) % 8) + 1;
        if (c < 10000) begin
          iv   = ($urandom % 4) != 0;
          ordy = int'($urandom % 8) < thr;
          fl   = ($urandom % 256) == 0;
        end else begin
          iv   = 1'b0;
          ordy = 1'b1;
          fl   = 1'b0;
        end
        wd = 8'($urandom);
        ifr.in_valid  = iv;
        ifr.in_data   = wd;
        ifr.out_ready = ordy;
        ifr.flush     = fl;
        #1;
        check({tag, "_count"}, 32'(ifr.count),
              (D == 0) ? 0 : q.size());
        if (32'(ifr.count) > 2 * D)
          check({tag, "_count_max"}, 32'(ifr.count), 2 * D);
        if (D > 0 && q.size() == 2 * D)
          check({tag, "_full_ready"}, 32'(ifr.in_ready), 0);
        if (D > 0 && q.size() == 0)
          check({tag, "_spurious"}, 32'(ifr.out_valid), 0);
        acc  = iv & ifr.in_ready;
        cons = ifr.out_valid & ordy;
        if (acc && (D == 0 || !fl)) q.push_back(wd);
        if (cons) begin
          if (q.size() > 0)
            check({tag, "_data"}, 32'(ifr.out_data),
                  32'(q.pop_front()));
          else
            check({tag, "_dup"}, 32'(cons), 0);
        end
        if (fl && D > 0) q.delete();
      end
      @(negedge clk);
      #1;
      check({tag, "_lost"}, q.size(), 0);
      check({tag, "_end_valid"}, 32'(ifr.out_valid), 0);
      done_cnt++;
    end
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    done_cnt = 0;
    go       = 1'b0;
    rst      = 1'b1;
    rst_r    = 1'b1;
    di.in_valid  = 1'b0;
    di.in_data   = '0;
    di.out_ready = 1'b0;
    di.flush     = 1'b0;

    tbl[0]  = '{1'b1, 5'd1,  1'b0, 1'b0, 1'b1, 1'b0, 5'h15, 3'd0};
    tbl[1]  = '{1'b1, 5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 5'h15, 3'd1};
    tbl[2]  = '{1'b1, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  3'd2};
    tbl[3]  = '{1'b1, 5'd4,  1'b0, 1'b0, 1'b1, 1'b1, 5'd1,  3'd3};
    tbl[4]  = '{1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  3'd4};
    tbl[5]  = '{1'b1, 5'd6,  1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  3'd4};
    tbl[6]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  3'd4};
    tbl[7]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  3'd3};
    tbl[8]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd3,  3'd2};
    tbl[9]  = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  3'd1};
    tbl[10] = '{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  3'd0};
    tbl[11] = '{1'b1, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  3'd0};
    tbl[12] = '{1'b1, 5'd8,  1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  3'd1};
    tbl[13] = '{1'b1, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  3'd2};
    tbl[14] = '{1'b1, 5'd9,  1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  3'd3};
    tbl[15] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd7,  3'd0};
    tbl[16] = '{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 5'd7,  3'd0};

    // reset values, held then released between edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      obs("rst_hold", 1'b1, 1'b0, 5'h15, 3'd0);
    end
    @(negedge clk);
    rst   = 1'b0;
    rst_r = 1'b0;
    @(negedge clk);
    #1;
    obs("rst_rel", 1'b1, 1'b0, 5'h15, 3'd0);

    // backpressure and flush table
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      di.in_valid  = tbl[i].iv;
      di.in_data   = tbl[i].id;
      di.out_ready = tbl[i].ordy;
      di.flush     = tbl[i].fl;
      #1;
      obs($sformatf("tbl%0d", i), tbl[i].eir, tbl[i].eov,
          tbl[i].eod, tbl[i].ecnt);
    end

    // streaming with out_ready held high
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      di.in_valid  = (i < 20);
      di.in_data   = 5'(i + 1);
      di.out_ready = 1'b1;
      di.flush     = 1'b0;
      #1;
      check("stream_valid", 32'(di.out_valid),
            32'(i >= 2 && i <= 21));
      if (di.out_valid)
        check("stream_data", 32'(di.out_data), i - 1);
      check("stream_ready", 32'(di.in_ready), 1);
      if (di.count > 3'd2)
        check("stream_count", 32'(di.count), 2);
    end

    // asynchronous reset while a word is presented
    @(negedge clk);
    di.in_valid  = 1'b1;
    di.in_data   = 5'd3;
    di.out_ready = 1'b0;
    @(negedge clk);
    di.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("arst_pre_valid", 32'(di.out_valid), 1);
    #1;
    rst = 1'b1;
    #1;
    obs("arst", 1'b1, 1'b0, 5'h15, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    obs("arst_rel", 1'b1, 1'b0, 5'h15, 3'd0);

    go = 1'b1;
    for (int t = 0; t < 12000 && done_cnt < 3; t++)
      @(negedge clk);
    check("stress_done", done_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
